// File: rtl/pipeline_hazard_ctrl.sv
// Hazard and stall sequencer for the 5-stage scpu pipeline: load-use bubbles, branch flushes,
// data-memory wait/timeout freeze. Optional perf counters under `HAZARD_PERF_EN.
module pipeline_hazard_ctrl #(
  parameter int unsigned LU_STALL_CYCLES = 1,
  parameter int unsigned MEM_TIMEOUT     = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic        id_uses_rs1,
  input  logic        id_uses_rs2,
  input  logic [4:0]  idex_rd,
  input  logic        idex_mem_read,
  input  logic        ex_branch_taken,
  input  logic        mem_req,
  input  logic        mem_ack,
  output logic        pc_stall,
  output logic        ifid_stall,
  output logic        ifid_flush,
  output logic        idex_zero,
  output logic        idex_stall,
  output logic        exmem_stall,
  output logic        memwb_bubble,
  output logic        mem_err,
  output logic [15:0] perf_stall_cnt,
  output logic [15:0] perf_flush_cnt
);

  typedef enum logic [1:0] {StRun, StLuStall, StMemWait} state_e;

  localparam logic [2:0] LuReload = 3'(LU_STALL_CYCLES - 1);
  localparam logic [7:0] WaitLast = 8'(MEM_TIMEOUT - 1);

  state_e     state_q, state_d;
  state_e     ret_q, ret_d;
  logic [2:0] lu_cnt_q, lu_cnt_d;
  logic [7:0] wait_cnt_q, wait_cnt_d;

  logic load_use, mem_busy;
  logic freeze, lu_out, br_out, err_raw;
  logic do_lu_step, do_run_rules;

  assign load_use = idex_mem_read && (idex_rd != 5'd0) &&
                    ((id_uses_rs1 && (id_rs1 == idex_rd)) ||
                     (id_uses_rs2 && (id_rs2 == idex_rd)));
  assign mem_busy = mem_req && !mem_ack;

  always_comb begin
    state_d      = state_q;
    ret_d        = ret_q;
    lu_cnt_d     = lu_cnt_q;
    wait_cnt_d   = wait_cnt_q;
    freeze       = 1'b0;
    lu_out       = 1'b0;
    br_out       = 1'b0;
    err_raw      = 1'b0;
    do_lu_step   = 1'b0;
    do_run_rules = 1'b0;

    case (state_q)
      StRun: begin
        if (mem_busy) begin
          freeze     = 1'b1;
          ret_d      = StRun;
          wait_cnt_d = 8'd1;
          state_d    = StMemWait;
        end else begin
          do_run_rules = 1'b1;
        end
      end
      StLuStall: begin
        if (mem_busy) begin
          freeze     = 1'b1;
          ret_d      = StLuStall;
          wait_cnt_d = 8'd1;
          state_d    = StMemWait;
        end else begin
          do_lu_step = 1'b1;
        end
      end
      StMemWait: begin
        // A dropped mem_req counts as an ack; only a busy access can time out.
        if (mem_busy && (wait_cnt_q != WaitLast)) begin
          freeze     = 1'b1;
          wait_cnt_d = wait_cnt_q + 8'd1;
        end else begin
          err_raw = mem_busy;
          if (ret_q == StLuStall) begin
            do_lu_step = 1'b1;
          end else begin
            do_run_rules = 1'b1;
          end
        end
      end
      default: state_d = StRun;
    endcase

    // The release cycle of a wait interrupted inside a bubble run stands in for the lost bubble.
    if (do_lu_step) begin
      lu_out   = 1'b1;
      lu_cnt_d = lu_cnt_q - 3'd1;
      state_d  = (lu_cnt_q <= 3'd1) ? StRun : StLuStall;
    end

    if (do_run_rules) begin
      state_d = StRun;
      if (ex_branch_taken) begin
        br_out = 1'b1;
      end else if (load_use) begin
        lu_out = 1'b1;
        if (LU_STALL_CYCLES > 1) begin
          lu_cnt_d = LuReload;
          state_d  = StLuStall;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StRun;
      ret_q      <= StRun;
      lu_cnt_q   <= 3'd0;
      wait_cnt_q <= 8'd0;
    end else begin
      state_q    <= state_d;
      ret_q      <= ret_d;
      lu_cnt_q   <= lu_cnt_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  assign pc_stall     = !rst && (freeze || lu_out);
  assign ifid_stall   = !rst && (freeze || lu_out);
  assign ifid_flush   = rst || br_out;
  assign idex_zero    = rst || lu_out || br_out;
  assign idex_stall   = !rst && freeze;
  assign exmem_stall  = !rst && freeze;
  assign memwb_bubble = !rst && freeze;
  assign mem_err      = !rst && err_raw;

`ifdef HAZARD_PERF_EN
  logic [15:0] stall_cnt_q, flush_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= 16'd0;
      flush_cnt_q <= 16'd0;
    end else begin
      if (pc_stall && (stall_cnt_q != 16'hFFFF)) begin
        stall_cnt_q <= stall_cnt_q + 16'd1;
      end
      if (ifid_flush && (flush_cnt_q != 16'hFFFF)) begin
        flush_cnt_q <= flush_cnt_q + 16'd1;
      end
    end
  end

  assign perf_stall_cnt = stall_cnt_q;
  assign perf_flush_cnt = flush_cnt_q;
`else
  assign perf_stall_cnt = 16'd0;
  assign perf_flush_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: two configurations driven in lockstep, checked
// against a vector table, hand sequences and a bubble/wait-counting reference model.
module tb_pipeline_hazard_ctrl;

  localparam int LuA = 1;
  localparam int ToA = 4;
  localparam int LuB = 3;
  localparam int ToB = 6;

  localparam logic [7:0] ONone = 8'b0000_0000;
  localparam logic [7:0] ORst  = 8'b0011_0000;
  localparam logic [7:0] OBr   = 8'b0011_0000;
  localparam logic [7:0] OLu   = 8'b1101_0000;
  localparam logic [7:0] OFrz  = 8'b1100_1110;
  localparam logic [7:0] OErr  = 8'b0000_0001;

  typedef struct packed {
    logic       rst;
    logic [4:0] rs1;
    logic       u1;
    logic [4:0] rs2;
    logic       u2;
    logic [4:0] rd;
    logic       mr;
    logic       br;
    logic       req;
    logic       ack;
  } in_t;

  typedef struct {
    in_t        in;
    logic [7:0] exp;
    string      name;
  } vec_t;

  typedef struct {
    bit waiting;
    int waited;
    int left;
    int stall_cnt;
    int flush_cnt;
  } mst_t;

  logic       clk;
  logic       rst;
  logic [4:0] id_rs1, id_rs2, idex_rd;
  logic       id_uses_rs1, id_uses_rs2, idex_mem_read, ex_branch_taken, mem_req, mem_ack;

  logic        a_pc_stall, a_ifid_stall, a_ifid_flush, a_idex_zero;
  logic        a_idex_stall, a_exmem_stall, a_memwb_bubble, a_mem_err;
  logic [15:0] a_perf_stall, a_perf_flush;
  logic        b_pc_stall, b_ifid_stall, b_ifid_flush, b_idex_zero;
  logic        b_idex_stall, b_exmem_stall, b_memwb_bubble, b_mem_err;
  logic [15:0] b_perf_stall, b_perf_flush;
  logic [7:0]  out_a, out_b;

  int n_checks = 0;
  int n_fail   = 0;
  mst_t ma, mb;
  vec_t tbl[$];

  pipeline_hazard_ctrl #(.LU_STALL_CYCLES(LuA), .MEM_TIMEOUT(ToA)) dut_a (
    .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .idex_rd(idex_rd),
    .idex_mem_read(idex_mem_read), .ex_branch_taken(ex_branch_taken),
    .mem_req(mem_req), .mem_ack(mem_ack),
    .pc_stall(a_pc_stall), .ifid_stall(a_ifid_stall), .ifid_flush(a_ifid_flush),
    .idex_zero(a_idex_zero), .idex_stall(a_idex_stall), .exmem_stall(a_exmem_stall),
    .memwb_bubble(a_memwb_bubble), .mem_err(a_mem_err),
    .perf_stall_cnt(a_perf_stall), .perf_flush_cnt(a_perf_flush)
  );

  pipeline_hazard_ctrl #(.LU_STALL_CYCLES(LuB), .MEM_TIMEOUT(ToB)) dut_b (
    .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .idex_rd(idex_rd),
    .idex_mem_read(idex_mem_read), .ex_branch_taken(ex_branch_taken),
    .mem_req(mem_req), .mem_ack(mem_ack),
    .pc_stall(b_pc_stall), .ifid_stall(b_ifid_stall), .ifid_flush(b_ifid_flush),
    .idex_zero(b_idex_zero), .idex_stall(b_idex_stall), .exmem_stall(b_exmem_stall),
    .memwb_bubble(b_memwb_bubble), .mem_err(b_mem_err),
    .perf_stall_cnt(b_perf_stall), .perf_flush_cnt(b_perf_flush)
  );

  assign out_a = {a_pc_stall, a_ifid_stall, a_ifid_flush, a_idex_zero,
                  a_idex_stall, a_exmem_stall, a_memwb_bubble, a_mem_err};
  assign out_b = {b_pc_stall, b_ifid_stall, b_ifid_flush, b_idex_zero,
                  b_idex_stall, b_exmem_stall, b_memwb_bubble, b_mem_err};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic in_t mk(input logic r, input logic [4:0] rs1, input logic u1,
                             input logic [4:0] rs2, input logic u2, input logic [4:0] rd,
                             input logic mr, input logic br, input logic req, input logic ack);
    in_t v;
    v.rst = r;  v.rs1 = rs1; v.u1 = u1; v.rs2 = rs2; v.u2 = u2;
    v.rd  = rd; v.mr  = mr;  v.br = br; v.req = req; v.ack = ack;
    return v;
  endfunction

  // Counts bubbles still owed and cycles spent frozen; perf outputs reflect the current state.
  function automatic void model_step(input in_t i, input int lu_cycles, input int tmo,
                                     input mst_t s, output logic [7:0] o, output mst_t n);
    bit lu, busy, check_busy, normal;
    n = s;
    o = ONone;
    check_busy = 1'b1;
    normal = 1'b1;
    if (i.rst) begin
      o = ORst;
      n.waiting = 0; n.waited = 0; n.left = 0; n.stall_cnt = 0; n.flush_cnt = 0;
      return;
    end
    lu = i.mr && (i.rd != 0) && ((i.u1 && i.rs1 == i.rd) || (i.u2 && i.rs2 == i.rd));
    busy = i.req && !i.ack;
    if (s.waiting) begin
      if (busy && s.waited < tmo - 1) begin
        o = OFrz;
        n.waited = s.waited + 1;
        normal = 1'b0;
      end else begin
        n.waiting = 0;
        n.waited = 0;
        check_busy = 1'b0;
        o[0] = busy;
      end
    end
    if (normal) begin
      if (check_busy && busy) begin
        o = OFrz;
        n.waiting = 1;
        n.waited = 1;
      end else if (s.left > 0) begin
        o = o | OLu;
        n.left = s.left - 1;
      end else if (i.br) begin
        o = o | OBr;
      end else if (lu) begin
        o = o | OLu;
        n.left = lu_cycles - 1;
      end
    end
`ifdef HAZARD_PERF_EN
    if (o[7] && s.stall_cnt < 65535) n.stall_cnt = s.stall_cnt + 1;
    if (o[5] && s.flush_cnt < 65535) n.flush_cnt = s.flush_cnt + 1;
`endif
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run_cycle(input in_t v, input string name, input bit chk_a,
                           input logic [7:0] exp_a, input bit chk_b, input logic [7:0] exp_b);
    logic [7:0] oa, ob;
    mst_t na, nb;
    rst = v.rst; id_rs1 = v.rs1; id_uses_rs1 = v.u1; id_rs2 = v.rs2; id_uses_rs2 = v.u2;
    idex_rd = v.rd; idex_mem_read = v.mr; ex_branch_taken = v.br;
    mem_req = v.req; mem_ack = v.ack;
    model_step(v, LuA, ToA, ma, oa, na);
    model_step(v, LuB, ToB, mb, ob, nb);
    @(negedge clk);
    check({name, " a model"}, 32'(out_a), 32'(oa));
    check({name, " b model"}, 32'(out_b), 32'(ob));
    check({name, " a perf_stall"}, 32'(a_perf_stall), 32'(ma.stall_cnt));
    check({name, " a perf_flush"}, 32'(a_perf_flush), 32'(ma.flush_cnt));
    check({name, " b perf_stall"}, 32'(b_perf_stall), 32'(mb.stall_cnt));
    check({name, " b perf_flush"}, 32'(b_perf_flush), 32'(mb.flush_cnt));
    if (chk_a) check({name, " a const"}, 32'(out_a), 32'(exp_a));
    if (chk_b) check({name, " b const"}, 32'(out_b), 32'(exp_b));
    @(posedge clk);
    ma = na;
    mb = nb;
    #1;
  endtask

  task automatic add(input in_t v, input logic [7:0] exp, input string name);
    vec_t t;
    t.in = v;
    t.exp = exp;
    t.name = name;
    tbl.push_back(t);
  endtask

  initial begin
    in_t idle, busy, ack, rsti, lu5;
    idle = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    busy = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    ack  = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    rsti = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    lu5  = mk(0, 5, 1, 0, 0, 5, 1, 0, 0, 0);

    ma = '{0, 0, 0, 0, 0};
    mb = '{0, 0, 0, 0, 0};
    rst = 1'b1; id_rs1 = '0; id_rs2 = '0; idex_rd = '0;
    id_uses_rs1 = 0; id_uses_rs2 = 0; idex_mem_read = 0; ex_branch_taken = 0;
    mem_req = 0; mem_ack = 0;
    @(posedge clk);
    #1;

    // Expected column refers to configuration A (one bubble, timeout 4).
    add(rsti, ORst, "reset");
    add(idle, ONone, "idle");
    add(lu5, OLu, "lu rs1");
    add(idle, ONone, "lu done");
    add(mk(0, 0, 1, 0, 0, 0, 1, 0, 0, 0), ONone, "rd x0");
    add(mk(0, 0, 0, 7, 1, 7, 1, 0, 0, 0), OLu, "lu rs2");
    add(mk(0, 9, 0, 0, 0, 9, 1, 0, 0, 0), ONone, "no use");
    add(mk(0, 5, 1, 0, 0, 5, 0, 0, 0, 0), ONone, "no load");
    add(mk(0, 5, 1, 0, 0, 5, 1, 1, 0, 0), OBr, "branch+lu");
    add(busy, OFrz, "wait 1");
    add(busy, OFrz, "wait 2");
    add(busy, OFrz, "wait 3");
    add(ack, ONone, "ack release");
    add(idle, ONone, "after ack");
    foreach (tbl[k]) run_cycle(tbl[k].in, tbl[k].name, 1, tbl[k].exp, 0, ONone);

    // Timeout: A times out on its 4th cycle and re-enters; B is still waiting.
    run_cycle(rsti, "to rst", 1, ORst, 1, ORst);
    run_cycle(idle, "to idle", 1, ONone, 1, ONone);
    run_cycle(busy, "to c1", 1, OFrz, 1, OFrz);
    run_cycle(busy, "to c2", 1, OFrz, 1, OFrz);
    run_cycle(busy, "to c3", 1, OFrz, 1, OFrz);
    run_cycle(busy, "to c4", 1, OErr, 1, OFrz);
    run_cycle(busy, "to c5", 1, OFrz, 1, OFrz);
    run_cycle(idle, "to reqdrop", 1, ONone, 1, ONone);

    // Nested: wait during B's second bubble, resume with one bubble left; then resets.
    run_cycle(rsti, "ns rst", 1, ORst, 1, ORst);
    run_cycle(idle, "ns idle", 1, ONone, 1, ONone);
    run_cycle(lu5, "ns lu", 1, OLu, 1, OLu);
    run_cycle(busy, "ns busy1", 1, OFrz, 1, OFrz);
    run_cycle(busy, "ns busy2", 1, OFrz, 1, OFrz);
    run_cycle(ack, "ns resume", 1, ONone, 1, OLu);
    run_cycle(idle, "ns last", 1, ONone, 1, OLu);
    run_cycle(idle, "ns run", 1, ONone, 1, ONone);
    run_cycle(busy, "rw busy1", 1, OFrz, 1, OFrz);
    run_cycle(busy, "rw busy2", 1, OFrz, 1, OFrz);
    run_cycle(mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 0), "rw rst", 1, ORst, 1, ORst);
    run_cycle(idle, "rw run", 1, ONone, 1, ONone);
    run_cycle(lu5, "rl lu", 1, OLu, 1, OLu);
    run_cycle(rsti, "rl rst", 1, ORst, 1, ORst);
    run_cycle(idle, "rl run", 1, ONone, 1, ONone);

    for (int k = 0; k < 3000; k++) begin
      in_t v;
      v = mk(1'($urandom_range(0, 63) == 0), 5'($urandom_range(0, 3)),
             1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
             5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 9) < 3),
             1'($urandom_range(0, 1)));
      run_cycle(v, "rand", 0, ONone, 0, ONone);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
